// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master:
//   - FSM state encoding (IDLE, SETUP, TRANSFER, TRAIL)
//   - SPI mode constants MODE0..MODE3, encoded as {CPOL, CPHA}
//   - default transfer width
//   - per-edge decode helpers (which SCLK edges sample MISO / drive MOSI)
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_TRANSFER = 2'd2;
  localparam logic [1:0] ST_TRAIL    = 2'd3;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Leading edges have an even index, trailing edges an odd one.
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  function automatic logic edge_samples(input logic cpha, input logic odd_edge);
    return (odd_edge == cpha);
  endfunction

  // CPHA=1 presents the next bit on every leading edge.
  // CPHA=0 already presented bit0 during setup, so it advances on trailing
  // edges, except the very last one where no bit is left to present.
  function automatic logic edge_drives(input logic cpha, input logic odd_edge,
                                       input logic last_edge);
    if (cpha) begin
      return !odd_edge;
    end else begin
      return odd_edge && !last_edge;
    end
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period tick generator. Counts 0..CLK_DIV-1 while enabled and wraps;
// tick is high in the last count of each half period, so the consumer acts
// on the following CLK edge.
// Ports:
//   CLK   in   system clock
//   RST_N in   asynchronous active-low reset
//   en    in   count enable
//   clr   in   synchronous clear (has priority over en)
//   tick  out  half-period boundary strobe (decode of the counter register)
// -----------------------------------------------------------------------------
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_div
      $error("spi_clk_gen: CLK_DIV must be within 1..255");
    end
  endgenerate

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;

  // Half-period counter with wrap at CLK_DIV-1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (en) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// 8-bit full-duplex SPI master, LSB first, all four CPOL/CPHA modes.
// A transfer accepted at cycle 0 drops SS at cycle 1, emits 16 SCLK edges at
// cycles 1+(k+1)*CLK_DIV and pulses DONE at cycle 1+17*CLK_DIV.
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   CPOL, CPHA           mode, latched on accept
//   START                transfer request, honoured only while idle
//   TX_DATA              byte to send, latched on accept
//   MISO                 serial data from the slave
//   SCLK, MOSI, SS       registered serial interface (SS active low)
//   RX_DATA              received byte, updated with DONE
//   BUSY, DONE           transfer in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  logic [1:0]        state_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              sclk_r;
  logic              mosi_r;
  logic              ss_r;
  logic              busy_r;
  logic              done_r;

  logic tick_s;
  logic en_s;
  logic clr_s;
  logic accept_s;
  logic edge_now_s;
  logic finish_s;
  logic last_s;
  logic sample_s;
  logic drive_s;

  // Per-cycle decode of what the serial datapath does this edge
  always_comb begin
    en_s       = 1'b0;
    clr_s      = 1'b0;
    accept_s   = 1'b0;
    edge_now_s = 1'b0;
    finish_s   = 1'b0;
    last_s     = (edge_cnt_r == LAST_EDGE);
    sample_s   = edge_samples(cpha_r, edge_cnt_r[0]);
    drive_s    = edge_drives(cpha_r, edge_cnt_r[0], last_s);
    if (state_r == ST_IDLE) begin
      clr_s    = 1'b1;
      accept_s = START;
    end else begin
      en_s = 1'b1;
    end
    // SETUP's tick is SCLK edge 0; every TRANSFER tick is the next edge.
    if ((state_r == ST_SETUP) || (state_r == ST_TRANSFER)) begin
      edge_now_s = tick_s;
    end else begin
      edge_now_s = 1'b0;
    end
    if (state_r == ST_TRAIL) begin
      finish_s = tick_s;
    end else begin
      finish_s = 1'b0;
    end
  end

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (en_s),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Transfer sequencing, mode latching and host handshake
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      ss_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cpol_r <= CPOL;
          if (START) begin
            state_r <= ST_SETUP;
            cpha_r  <= CPHA;
            ss_r    <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tick_s) begin
            state_r <= ST_TRANSFER;
          end
        end
        ST_TRANSFER: begin
          if (tick_s && last_s) begin
            state_r <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick_s) begin
            state_r   <= ST_IDLE;
            ss_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= rx_sh_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ss_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Serial datapath: SCLK, MOSI, edge counter and the two shifters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      tx_sh_r    <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
    end else if (accept_s) begin
      // CPHA=0 puts bit0 on MOSI now, so the shifter starts one bit ahead.
      sclk_r     <= CPOL;
      mosi_r     <= CPHA ? 1'b0 : TX_DATA[0];
      tx_sh_r    <= CPHA ? TX_DATA : {1'b0, TX_DATA[DATA_W-1:1]};
      rx_sh_r    <= {DATA_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      sclk_r <= CPOL;
    end else if (edge_now_s) begin
      sclk_r <= ~sclk_r;
      if (!last_s) begin
        edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
      end
      if (sample_s) begin
        rx_sh_r <= {MISO, rx_sh_r[DATA_W-1:1]};
      end
      if (drive_s) begin
        mosi_r  <= tx_sh_r[0];
        tx_sh_r <= {1'b0, tx_sh_r[DATA_W-1:1]};
      end
    end else if (finish_s) begin
      sclk_r <= cpol_r;
      mosi_r <= 1'b0;
    end else begin
      sclk_r <= sclk_r;
    end
  end

  assign SCLK    = sclk_r;
  assign MOSI    = mosi_r;
  assign SS      = ss_r;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign RX_DATA = rx_data_r;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Two masters (CLK_DIV=2 and CLK_DIV=1) share one behavioural LSB-first SPI
// slave through a selector. Expected RX_DATA / slave contents are queued when
// a transfer is launched and popped when DONE appears.
// -----------------------------------------------------------------------------
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       cpol    = 1'b1;
  logic       cpha    = 1'b0;
  logic       start0  = 1'b0;
  logic       start1  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso;
  logic       use1    = 1'b0;

  logic       sclk0, mosi0, ss0, busy0, done0;
  logic [7:0] rx0;
  logic       sclk1, mosi1, ss1, busy1, done1;
  logic [7:0] rx1;

  spi_master #(.CLK_DIV(2), .DATA_W(8)) dut0 (
    .CLK(clk), .RST_N(rst_n), .CPOL(cpol), .CPHA(cpha), .START(start0),
    .TX_DATA(tx_data), .MISO(miso), .SCLK(sclk0), .MOSI(mosi0), .SS(ss0),
    .RX_DATA(rx0), .BUSY(busy0), .DONE(done0));

  spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CPOL(cpol), .CPHA(cpha), .START(start1),
    .TX_DATA(tx_data), .MISO(miso), .SCLK(sclk1), .MOSI(mosi1), .SS(ss1),
    .RX_DATA(rx1), .BUSY(busy1), .DONE(done1));

  logic       sclk_w, mosi_w, ss_w, busy_w, done_w;
  logic [7:0] rx_w;
  assign sclk_w = use1 ? sclk1 : sclk0;
  assign mosi_w = use1 ? mosi1 : mosi0;
  assign ss_w   = use1 ? ss1   : ss0;
  assign busy_w = use1 ? busy1 : busy0;
  assign done_w = use1 ? done1 : done0;
  assign rx_w   = use1 ? rx1   : rx0;

  // Behavioural slave: loads s_mem on SS fall, shifts LSB first.
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic [7:0] s_mem  = 8'h00;
  logic [7:0] s_tx   = 8'h00;
  logic [7:0] s_rx   = 8'h00;
  logic       s_miso_r = 1'b0;
  assign miso = s_cpha ? s_miso_r : s_tx[0];

  always @(negedge ss_w) begin
    s_tx     <= s_mem;
    s_rx     <= 8'h00;
    s_miso_r <= 1'b0;
  end

  always @(sclk_w) begin
    if (ss_w === 1'b0) begin
      if ((sclk_w !== s_cpol) ^ s_cpha) begin
        s_rx <= {mosi_w, s_rx[7:1]};
      end else if (s_cpha) begin
        s_miso_r <= s_tx[0];
        s_tx     <= {1'b0, s_tx[7:1]};
      end else begin
        s_tx <= {1'b0, s_tx[7:1]};
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_sl_q[$];

  int         obs_done_cyc;
  int         obs_edges;
  logic       obs_ss1, obs_busy1, obs_mosi1, obs_idle_sclk, obs_after_sclk;
  logic [7:0] obs_rx, obs_slave;

  // Launches one transfer, scrambles TX_DATA/CPHA after accept, records timing.
  task automatic do_xfer(input logic d1, input logic [7:0] tx, input logic [7:0] mem,
                         input logic m_cpol, input logic m_cpha);
    logic prev;
    exp_rx_q.push_back(mem);
    exp_sl_q.push_back(tx);
    @(negedge clk);
    use1 = d1; cpol = m_cpol; cpha = m_cpha; s_cpol = m_cpol; s_cpha = m_cpha;
    s_mem = mem; tx_data = tx;
    repeat (3) @(negedge clk);
    obs_idle_sclk = sclk_w;
    prev = sclk_w;
    if (d1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; tx_data = ~tx; cpha = ~m_cpha;
    obs_done_cyc = 0; obs_edges = 0; obs_rx = 8'h00; obs_slave = 8'h00;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin obs_ss1 = ss_w; obs_busy1 = busy_w; obs_mosi1 = mosi_w; end
      if (sclk_w !== prev) obs_edges++;
      prev = sclk_w;
      if (done_w === 1'b1) begin
        obs_done_cyc = n; obs_rx = rx_w; obs_slave = s_rx;
        break;
      end
    end
    cpha = m_cpha;
    @(negedge clk);
    obs_after_sclk = sclk_w;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (ss0 !== 1'b1) begin n_bad++; $display("FAIL reset_ss: got %b want 1", ss0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done0); end
    n_cmp++; if (rx0 !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx0); end
    rst_n = 1'b1;
    cpol  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] e_rx, e_sl;
    exp_rx_q.delete(); exp_sl_q.delete();
    do_xfer(1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0);
    e_rx = exp_rx_q.pop_front(); e_sl = exp_sl_q.pop_front();
    n_cmp++; if (obs_ss1 !== 1'b0) begin n_bad++; $display("FAIL mode0_ss_c1: got %b want 0", obs_ss1); end
    n_cmp++; if (obs_busy1 !== 1'b1) begin n_bad++; $display("FAIL mode0_busy_c1: got %b want 1", obs_busy1); end
    n_cmp++; if (obs_mosi1 !== 1'b1) begin n_bad++; $display("FAIL mode0_mosi_c1: got %b want 1", obs_mosi1); end
    n_cmp++; if (obs_edges != 16) begin n_bad++; $display("FAIL mode0_edges: got %0d want 16", obs_edges); end
    n_cmp++; if (obs_done_cyc != 35) begin n_bad++; $display("FAIL mode0_done_cyc: got %0d want 35", obs_done_cyc); end
    n_cmp++; if (obs_rx !== e_rx) begin n_bad++; $display("FAIL mode0_rx: got %h want %h", obs_rx, e_rx); end
    n_cmp++; if (obs_slave !== e_sl) begin n_bad++; $display("FAIL mode0_slave: got %h want %h", obs_slave, e_sl); end
  endtask

  task automatic test_modes();
    logic [1:0] modes [3];
    logic [7:0] e_rx, e_sl;
    logic [1:0] md;
    logic       e_mosi;
    modes[0] = MODE1; modes[1] = MODE2; modes[2] = MODE3;
    for (int i = 0; i < 3; i++) begin
      md = modes[i];
      exp_rx_q.delete(); exp_sl_q.delete();
      do_xfer(1'b0, 8'h81, 8'h7E, md[1], md[0]);
      e_rx = exp_rx_q.pop_front(); e_sl = exp_sl_q.pop_front();
      e_mosi = md[0] ? 1'b0 : 1'b1;
      n_cmp++; if (obs_rx !== e_rx) begin n_bad++; $display("FAIL mode%0d_rx: got %h want %h", md, obs_rx, e_rx); end
      n_cmp++; if (obs_slave !== e_sl) begin n_bad++; $display("FAIL mode%0d_slave: got %h want %h", md, obs_slave, e_sl); end
      n_cmp++; if (obs_idle_sclk !== md[1]) begin n_bad++; $display("FAIL mode%0d_idle_before: got %b want %b", md, obs_idle_sclk, md[1]); end
      n_cmp++; if (obs_after_sclk !== md[1]) begin n_bad++; $display("FAIL mode%0d_idle_after: got %b want %b", md, obs_after_sclk, md[1]); end
      n_cmp++; if (obs_mosi1 !== e_mosi) begin n_bad++; $display("FAIL mode%0d_mosi_c1: got %b want %b", md, obs_mosi1, e_mosi); end
      n_cmp++; if (obs_done_cyc != 35) begin n_bad++; $display("FAIL mode%0d_done_cyc: got %0d want 35", md, obs_done_cyc); end
    end
  endtask

  task automatic test_back_to_back();
    int first, second, ss_hi, ndone, extra;
    logic [7:0] e_rx, e_sl;
    exp_rx_q.delete(); exp_sl_q.delete();
    @(negedge clk);
    use1 = 1'b0; cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
    s_mem = 8'h3C; tx_data = 8'h0F;
    exp_rx_q.push_back(8'h3C); exp_sl_q.push_back(8'h0F);
    exp_rx_q.push_back(8'hC3); exp_sl_q.push_back(8'hF0);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    first = 0; second = 0; ss_hi = 0; ndone = 0;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 2) begin tx_data = 8'hF0; s_mem = 8'hC3; end
      if ((ss0 === 1'b1) && !((done0 === 1'b1) && (ndone == 1))) ss_hi++;
      if (done0 === 1'b1) begin
        ndone++;
        if (exp_rx_q.size() > 0) begin
          e_rx = exp_rx_q.pop_front(); e_sl = exp_sl_q.pop_front();
          n_cmp++; if (rx0 !== e_rx) begin n_bad++; $display("FAIL b2b_rx%0d: got %h want %h", ndone, rx0, e_rx); end
          n_cmp++; if (s_rx !== e_sl) begin n_bad++; $display("FAIL b2b_slave%0d: got %h want %h", ndone, s_rx, e_sl); end
        end
        if (ndone == 1) first = n;
        else begin second = n; start0 = 1'b0; break; end
      end
    end
    start0 = 1'b0;
    n_cmp++; if (first != 35) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 35", first); end
    n_cmp++; if ((second - first) != 35) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 35", second - first); end
    n_cmp++; if (ss_hi != 1) begin n_bad++; $display("FAIL b2b_ss_gap: got %0d want 1", ss_hi); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((done0 === 1'b1) || (busy0 === 1'b1)) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL b2b_no_queue: got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [7:0] e_rx, e_sl;
    exp_rx_q.delete(); exp_sl_q.delete();
    @(negedge clk);
    use1 = 1'b0; cpol = 1'b0; cpha = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0;
    s_mem = 8'h99; tx_data = 8'h66;
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (11) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy0); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ss0 !== 1'b1) begin n_bad++; $display("FAIL rstmid_ss: got %b want 1", ss0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_sclk: got %b want 0", sclk0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    dones = 0;
    repeat (3) begin @(negedge clk); if (done0 === 1'b1) dones++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done0 === 1'b1) dones++; end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    do_xfer(1'b0, 8'h5A, 8'hC6, 1'b1, 1'b0);
    e_rx = exp_rx_q.pop_front(); e_sl = exp_sl_q.pop_front();
    n_cmp++; if (obs_rx !== e_rx) begin n_bad++; $display("FAIL rstmid_after_rx: got %h want %h", obs_rx, e_rx); end
    n_cmp++; if (obs_slave !== e_sl) begin n_bad++; $display("FAIL rstmid_after_slave: got %h want %h", obs_slave, e_sl); end
  endtask

  task automatic test_div1();
    logic [7:0] e_rx, e_sl;
    exp_rx_q.delete(); exp_sl_q.delete();
    do_xfer(1'b1, 8'h55, 8'hAA, 1'b0, 1'b0);
    e_rx = exp_rx_q.pop_front(); e_sl = exp_sl_q.pop_front();
    n_cmp++; if (obs_done_cyc != 18) begin n_bad++; $display("FAIL div1_done_cyc: got %0d want 18", obs_done_cyc); end
    n_cmp++; if (obs_edges != 16) begin n_bad++; $display("FAIL div1_edges: got %0d want 16", obs_edges); end
    n_cmp++; if (obs_rx !== e_rx) begin n_bad++; $display("FAIL div1_rx: got %h want %h", obs_rx, e_rx); end
    n_cmp++; if (obs_slave !== e_sl) begin n_bad++; $display("FAIL div1_slave: got %h want %h", obs_slave, e_sl); end
    use1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- 8-bit SPI master. Sits directly upstream of the SPI slave and drives its SCLK, MOSI and SS inputs; it captures the slave's MISO.
- A host-side START/BUSY/DONE handshake launches one full-duplex byte exchange in any of the four CPOL/CPHA modes.
- Bits go LSB first, which matches the slave's shift direction: slave MISO is its shift-state LSB, and received bits enter at its MSB.
- SCLK is derived from CLK by a programmable divider.

Parameters:
- CLK_DIV, 2, CLK cycles per SCLK half-period. Legal range 1..255; elaboration fails outside it.
- DATA_W, 8, bits per transfer. Only 8 is verified.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CPOL  in  1  idle level of SCLK.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- START  in  1  request a transfer; sampled only when BUSY=0.
- TX_DATA  in  8  byte to send; latched on accept.
- MISO  in  1  serial data from the slave.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data to the slave.
- SS  out  1  active-low slave select.
- RX_DATA  out  8  received byte; valid from DONE until the next accept.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (RST_N=0, async): state IDLE; SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0; all counters, shift registers and latched mode bits = 0.
- Reset asserted mid-transfer aborts it immediately: SS rises, and no DONE is produced.
- IDLE:
  - The latched polarity register follows CPOL every cycle, so SCLK = CPOL delayed by one CLK.
  - START=1 at a rising edge (cycle 0) latches TX_DATA, CPOL and CPHA, then enters SETUP.
  - CPOL/CPHA/TX_DATA changes after accept are ignored until the next accept.
- SETUP: SS=0 and BUSY=1 from cycle 1, held for CLK_DIV cycles (lead time).
  - CPHA=0: MOSI = TX bit0 from cycle 1.
  - CPHA=1: MOSI holds 0 until the first edge.
- TRANSFER: 16 SCLK edges, k=0..15.
  - Edge k occurs at cycle 1+(k+1)*CLK_DIV; SCLK toggles there.
  - Even k is a leading edge; odd k is a trailing edge.
  - CPHA=0: sample on even k; MOSI advances to the next bit on odd k=1,3,..,13. No advance on k=15.
  - CPHA=1: MOSI drives bit k/2 on even k; sample on odd k.
  - Sampling captures MISO as present before that CLK edge; the receive shift is rx <= {MISO, rx[7:1]}, so the first received bit ends at bit0.
  - After k=15, SCLK equals the latched CPOL.
- TRAIL: SS stays 0 for CLK_DIV cycles after edge 15, and MOSI holds its last bit.
- Completion, at cycle 1+17*CLK_DIV:
  - SS=1, BUSY=0, DONE=1 for exactly one cycle, RX_DATA updated, MOSI=0, state IDLE.
  - CLK_DIV=2 gives cycle 35.
- Back-to-back:
  - START high in the DONE cycle is accepted, so SS is high for exactly 1 CLK between transfers.
  - START while BUSY=1 is ignored and not queued.
- Counters:
  - Half-period counter counts 0..CLK_DIV-1 and wraps, producing a tick.
  - Edge counter is 4 bits, counts 0..15 and saturates; the state exits at 15.
- Outputs are registered; no combinational path from inputs to SCLK, MOSI or SS.

Decomposition:
- spi_pkg holds the state encoding (IDLE, SETUP, TRANSFER, TRAIL), the mode constants MODE0..MODE3 = {CPOL,CPHA}, and the DATA_W default.
- One sub-module, spi_clk_gen: half-period tick counter with enable and synchronous clear, parameterised by CLK_DIV.
- All else lives in spi_master: FSM, edge counter, TX/RX shifters.

Test Plan:
- Bench hookup: all scenarios connect the existing SPI slave model, with its phase input tied to CPHA^CPOL and CLK_DIV=2 unless stated.
- Mode 0: slave memory 0x3C, TX_DATA=0xA5 -> SS low at cycle 1, 16 SCLK edges, DONE at cycle 35, RX_DATA=0x3C, slave shift state=0xA5.
- Modes 1/2/3: TX_DATA=0x81, slave 0x7E -> RX_DATA=0x7E and slave state=0x81 in each mode; SCLK idles at CPOL before and after the transfer.
- Back-to-back: START held high, TX 0x0F then 0xF0 -> two DONE pulses 35 cycles apart with SS high exactly 1 cycle between them; START pulses during BUSY are ignored.
- Reset mid-transfer: RST_N low at cycle 12 -> SS=1, SCLK=0, BUSY=0 immediately, no DONE; a new transfer after release returns correct data.
- CLK_DIV=1: TX 0x55, slave 0xAA -> DONE at cycle 18, RX_DATA=0xAA.
